// File: rtl/dmemory_32.sv
// Word-addressed 32-bit data memory with a registered, write-first read port.
// The array has no reset so it maps onto single-port synchronous block RAM.
module dmemory_32 #(
    parameter int unsigned WORD_ADDR_BITS = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2 ** WORD_ADDR_BITS;

    logic [DATA_W-1:0]         mem [DEPTH];
    logic [WORD_ADDR_BITS-1:0] index_c;
    logic [DATA_W-1:0]         read_data_d;
    logic [DATA_W-1:0]         read_data_q;

    // Byte offset and high address bits are dropped, so accesses alias modulo depth.
    assign index_c = address[WORD_ADDR_BITS+1:2];

    // Write-first: a write returns the new word on the same edge.
    always_comb begin
        read_data_d = mem[index_c];
        if (memWrite) begin
            read_data_d = writeData;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && memWrite) begin
            mem[index_c] <= writeData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data_q <= DATA_W'(0);
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign readData = read_data_q;

endmodule

// File: tb/tb_dmemory_32.sv
// Scoreboard bench for dmemory_32: stimulus pushes expected read words, a monitor pops and compares.
module tb_dmemory_32;

    localparam int unsigned WORDS = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] writeData = 32'h0;
    logic [31:0] readData;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    bit   [31:0] model [WORDS];

    dmemory_32 #(.WORD_ADDR_BITS(14)) dut (
        .clock    (clock),
        .reset    (reset),
        .memWrite (memWrite),
        .address  (address),
        .writeData(writeData),
        .readData (readData)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the reference model decides the word due after the next edge.
    task automatic drive(input bit rst, input bit we, input logic [31:0] addr,
                         input logic [31:0] data, input string name);
        int unsigned idx;
        logic [31:0] exp;
        @(negedge clock);
        reset     = rst;
        memWrite  = we;
        address   = addr;
        writeData = data;
        idx = (addr / 4) % WORDS;
        if (rst) begin
            exp = 32'h0;
        end else if (we) begin
            model[idx] = data;
            exp = data;
        end else begin
            exp = model[idx];
        end
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    function automatic logic [31:0] pool_addr(input int k);
        int unsigned idx;
        idx = (k * 1021 + 3) % WORDS;
        return (($urandom() % 65536) * 65536) + idx * 4 + ($urandom() % 4);
    endfunction

    // Monitor: every edge with pending stimulus produces one registered word.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, readData, e);
            end
        end
    end

    initial begin
        int wait_cycles;
        #1;
        reset = 1'b1;
        #1;
        check("reset_init", readData, 32'h0);
        drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, "reset_hold");

        drive(1'b0, 1'b1, 32'h10, 32'hABCD_1234, "write");
        drive(1'b0, 1'b1, 32'h10, 32'h0000_0000, "overwrite");
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h10, 32'hABCD_1234, "read_only");
        drive(1'b0, 1'b1, 32'h10, 32'hABCD_1234, "rewrite");
        drive(1'b0, 1'b0, 32'h10, 32'h0, "read_back");
        drive(1'b0, 1'b1, 32'h20, 32'h1122_3344, "write_20");
        drive(1'b0, 1'b0, 32'h23, 32'h0, "unaligned_23");
        drive(1'b0, 1'b0, 32'h0001_0020, 32'h0, "alias_10020");

        drive(1'b0, 1'b1, 32'h10, 32'h55AA_55AA, "write_pre_reset");
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_async", readData, 32'h0);
        drive(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, "reset_write_ignored");
        drive(1'b0, 1'b0, 32'h10, 32'h0, "read_after_reset");
        @(posedge clock);
        #2;
        address   = 32'h20;
        writeData = 32'h1234_5678;
        memWrite  = 1'b1;
        #1;
        check("hold_between_edges", readData, 32'h55AA_55AA);

        for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, pool_addr(k), $urandom(), "rand_fill");
        for (int i = 0; i < 300; i++) begin
            drive(($urandom() % 20) == 0, $urandom() % 2 == 1,
                  pool_addr(int'($urandom() % 16)), $urandom(), "rand_access");
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
